dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-stated, byte-addressed 64-bit memory behind a valid/ready request/response pair.
// Optional macro DMEM_MISALIGN_CHECK_EN: error on misaligned access instead of aligning the address down.
module dmem_responder #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_width,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [2:0]  width;
    logic [63:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  req_t        cap, live, acc;
  logic        accept, enter_resp, mem_we;
  logic [63:0] mem [DEPTH];

  logic [2:0]    amask, lane;
  logic          oob, illegal, misal, err;
  logic [AW-1:0] idx;
  logic [7:0]    be;
  logic [63:0]   wd_sh, rd_sh, rd_ext;

  assign live       = '{write: req_write, addr: req_addr, width: req_width, wdata: req_wdata};
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_n == RESP) && (state != RESP);
  // With zero wait states the access happens on the accept edge, before capture.
  assign acc        = (state == IDLE) ? live : cap;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) state_n = RESP;
        else begin
          state_n = WAIT;
          cnt_n   = WLOAD;
        end
      end
      WAIT: if (cnt == 4'd0) state_n = RESP;
            else             cnt_n   = cnt - 4'd1;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (acc.width[1:0])
      2'b00:   begin amask = 3'd0; be = 8'h01; end
      2'b01:   begin amask = 3'd1; be = 8'h03; end
      2'b10:   begin amask = 3'd3; be = 8'h0f; end
      default: begin amask = 3'd7; be = 8'hff; end
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misal = |(acc.addr[2:0] & amask);
    lane  = acc.addr[2:0];
`else
    misal = 1'b0;
    lane  = acc.addr[2:0] & ~amask;
`endif
    oob     = |acc.addr[63:AW+3];
    illegal = (acc.width == 3'b111);
    err     = oob || illegal || misal;
    idx     = acc.addr[3 +: AW];
    be      = be << lane;
    wd_sh   = acc.wdata << {lane, 3'b000};
    rd_sh   = mem[idx] >> {lane, 3'b000};
    case (acc.width)
      3'b000:  rd_ext = {{56{rd_sh[7]}},  rd_sh[7:0]};
      3'b001:  rd_ext = {{48{rd_sh[15]}}, rd_sh[15:0]};
      3'b010:  rd_ext = {{32{rd_sh[31]}}, rd_sh[31:0]};
      3'b100:  rd_ext = {56'd0, rd_sh[7:0]};
      3'b101:  rd_ext = {48'd0, rd_sh[15:0]};
      3'b110:  rd_ext = {32'd0, rd_sh[31:0]};
      default: rd_ext = rd_sh;
    endcase
  end

  assign mem_we = enter_resp && acc.write && !err && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap       <= '0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) cap <= live;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || acc.write) ? 64'd0 : rd_ext;
      end
    end
  end

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wd_sh[b*8 +: 8];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, latency/backpressure/reset checks.
module tb_dmem_responder;
  localparam int DEPTH       = 512;
  localparam int WAIT_CYCLES = 2;
  localparam int NBYTES      = DEPTH * 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_width = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [63:0] rsp_rdata;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [NBYTES];
  int         n_vec = 0, n_err = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic w, input logic [63:0] a, input logic [2:0] f,
                                input logic [63:0] wd, output logic [63:0] rd, output logic e);
    int sz, base;
    logic [63:0] v;
    rd = '0; e = 1'b0;
    case (f)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2, 3'd6: sz = 4;
      3'd3:       sz = 8;
      default:    sz = 0;
    endcase
    if (sz == 0 || a >= 64'(NBYTES)) begin e = 1'b1; return; end
    base = int'(a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (base % sz != 0) begin e = 1'b1; return; end
`else
    base = base - (base % sz);
`endif
    if (w) begin
      for (int i = 0; i < sz; i++) mem_m[base + i] = wd[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[base + i];
    if (f < 3'd3 && v[8*sz - 1])
      for (int b = 8*sz; b < 64; b++) v[b] = 1'b1;
    rd = v;
  endfunction

  // One full transaction; hold = cycles of rsp_ready=0 in RESP, with ignored request pulses.
  task automatic xact(input logic w, input logic [63:0] a, input logic [2:0] f,
                      input logic [63:0] wd, input int hold);
    exp_t e;
    int   lat, low;
    model(w, a, f, wd, e.rdata, e.err);
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_width = f; req_wdata = wd;
    rsp_ready = 1'b0;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = '1; req_wdata = '1; req_width = 3'd3; req_write = ~w;
    lat = 0; low = 0;
    while (!rsp_valid && lat < 40) begin
      if (!req_ready) low++;
      @(posedge clock); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(WAIT_CYCLES));
    for (int h = 0; h < hold; h++) begin
      if (!req_ready) low++;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, sb[0].rdata);
      chk("hold_err", 64'(rsp_err), 64'(sb[0].err));
      req_valid = h[0]; req_write = 1'b1; req_addr = 64'h10; req_width = 3'd3;
      req_wdata = 64'hdead_beef_cafe_f00d;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    if (!req_ready) low++;
    e = sb.pop_front();
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 64'(rsp_err), 64'(e.err));
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("ready_low_cycles", 64'(low), 64'(WAIT_CYCLES + 1 + hold));
    chk("back_to_idle", {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      xact(1'b1, 64'(i * 8), 3'd3, {32'(i) ^ 32'h5a5a_0000, ~32'(i)}, 0);

    xact(1'b1, 64'h10, 3'd3, 64'h1122_3344_5566_7788, 0);
    xact(1'b0, 64'h10, 3'd3, 64'h0, 0);
    chk("d_load_0x10", rsp_rdata, 64'h1122_3344_5566_7788);
    xact(1'b0, 64'h17, 3'd0, 64'h0, 0);
    chk("b_load_0x17", rsp_rdata, 64'h0000_0000_0000_0011);
    xact(1'b1, 64'h10, 3'd0, 64'hff, 0);
    xact(1'b0, 64'h10, 3'd0, 64'h0, 0);
    chk("b_load_0x10", rsp_rdata, 64'hffff_ffff_ffff_ffff);
    xact(1'b0, 64'h10, 3'd4, 64'h0, 0);
    chk("bu_load_0x10", rsp_rdata, 64'h0000_0000_0000_00ff);
    xact(1'b0, 64'h14, 3'd2, 64'h0, 0);
    chk("w_load_0x14", rsp_rdata, 64'h0000_0000_1122_3344);

    xact(1'b0, 64'h10, 3'd3, 64'h0, 5);
    xact(1'b0, 64'h10, 3'd3, 64'h0, 0);
    chk("no_write_under_bp", rsp_rdata, 64'h1122_3344_5566_77ff);

    xact(1'b1, 64'h1000, 3'd3, 64'h0123_4567_89ab_cdef, 0);
    chk("oob_store_err", 64'(rsp_err), 64'd1);
    xact(1'b0, 64'h8, 3'd7, 64'h0, 0);
    chk("illegal_width_err", 64'(rsp_err), 64'd1);
    for (int i = 0; i < DEPTH; i++) xact(1'b0, 64'(i * 8), 3'd3, 64'h0, 0);

    xact(1'b0, 64'h11, 3'd1, 64'h0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("h_misaligned_err", 64'(rsp_err), 64'd1);
`else
    chk("h_aligned_down", rsp_rdata, 64'h0000_0000_0000_77ff);
`endif

    for (int t = 0; t < 80; t++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 9) == 0) ? 64'(NBYTES + $urandom_range(0, 255))
                                      : 64'($urandom_range(0, NBYTES - 1));
      xact(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)),
           {$urandom, $urandom}, $urandom_range(0, 2));
    end

    xact(1'b0, 64'h10, 3'd3, 64'h0, 0);
    xact(1'b0, 64'h20, 3'd3, 64'h0, 0);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_width = 3'd3;
    req_wdata = 64'haaaa_bbbb_cccc_dddd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midwait_rst_ready", 64'(req_ready), 64'd1);
    chk("midwait_rst_valid", 64'(rsp_valid), 64'd0);
    chk("midwait_rst_rdata", rsp_rdata, 64'd0);
    chk("midwait_rst_err", 64'(rsp_err), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    xact(1'b0, 64'h20, 3'd3, 64'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
